// File: rtl/serial_frame_rx.sv
// Framed serial-to-parallel receiver: start bit (1), WIDTH data bits LSB-first,
// optional even-parity bit, stop bit (0); one bit per clk, no oversampling.
module serial_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_in) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            S_DATA: begin
                shift_d[cnt_q] = data_in;
                par_d          = par_q ^ data_in;
                // Counter holds on the last bit instead of wrapping; IDLE re-zeroes it.
                if (cnt_q == CNT_LAST) begin
                    state_d = PARITY_EN ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                par_d   = par_q ^ data_in;
                state_d = S_STOP;
            end
            S_STOP: begin
                // A high stop bit is a framing error and is never reused as a start bit.
                state_d = S_IDLE;
                if (!data_in) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = PARITY_EN & par_q;
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: one instance with parity, one without,
// frames built bit by bit and expected pulses queued with their due cycle.
module tb_serial_frame_rx;

    logic       clk;
    logic       rst;
    logic       din_p, din_n;
    logic [7:0] dout_p, dout_n;
    logic       valid_p, valid_n;
    logic       perr_p, perr_n;
    logic       ferr_p, ferr_n;
    logic       busy_p, busy_n;

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut_p (
        .clk        (clk),
        .rst        (rst),
        .data_in    (din_p),
        .data_out   (dout_p),
        .data_valid (valid_p),
        .parity_err (perr_p),
        .frame_err  (ferr_p),
        .busy       (busy_p)
    );

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b0)) dut_n (
        .clk        (clk),
        .rst        (rst),
        .data_in    (din_n),
        .data_out   (dout_n),
        .data_valid (valid_n),
        .parity_err (perr_n),
        .frame_err  (ferr_n),
        .busy       (busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         due;
    } exp_t;

    exp_t       q_p[$];
    exp_t       q_n[$];
    logic [7:0] last_p, last_n;
    int         cyc;
    int         n_checks;
    int         n_fail;

    // Pops the scoreboard whenever an instance emits a pulse.
    task automatic mon(input bit is_n);
        logic       v, pe, fe;
        logic [7:0] d;
        exp_t       e;
        string      nm;
        bit         empty;
        v     = is_n ? valid_n : valid_p;
        pe    = is_n ? perr_n  : perr_p;
        fe    = is_n ? ferr_n  : ferr_p;
        d     = is_n ? dout_n  : dout_p;
        nm    = is_n ? "nopar" : "par";
        empty = is_n ? (q_n.size() == 0) : (q_p.size() == 0);
        if (v === 1'b1 || fe === 1'b1) begin
            n_checks++;
            if (empty) begin
                n_fail++;
                $display("FAIL %s unexpected_pulse cycle=%0d valid=%b frame_err=%b, required no pulse",
                         nm, cyc, v, fe);
            end else begin
                if (is_n) e = q_n.pop_front();
                else      e = q_p.pop_front();
                if (cyc !== e.due || d !== e.data || v !== !e.ferr || pe !== e.perr || fe !== e.ferr) begin
                    n_fail++;
                    $display("FAIL %s frame_result got cycle=%0d data=%h valid=%b perr=%b ferr=%b, required cycle=%0d data=%h valid=%b perr=%b ferr=%b",
                             nm, cyc, d, v, pe, fe, e.due, e.data, !e.ferr, e.perr, e.ferr);
                end
            end
        end
    endtask

    task automatic send_bit(input logic bp, input logic bn);
        din_p = bp;
        din_n = bn;
        @(posedge clk);
        #1;
        cyc++;
        mon(1'b0);
        mon(1'b1);
    endtask

    task automatic send_frame_p(input logic [7:0] d, input logic p, input logic stop, output int busy_hi);
        exp_t e;
        e.data = stop ? last_p : d;
        e.perr = !stop && ((^d) ^ p);
        e.ferr = stop;
        e.due  = cyc + 11;
        q_p.push_back(e);
        if (!stop) last_p = d;
        busy_hi = 0;
        send_bit(1'b1, 1'b0);
        if (busy_p === 1'b1) busy_hi++;
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], 1'b0);
            if (busy_p === 1'b1) busy_hi++;
        end
        send_bit(p, 1'b0);
        if (busy_p === 1'b1) busy_hi++;
        send_bit(stop, 1'b0);
        if (busy_p === 1'b1) busy_hi++;
    endtask

    task automatic send_frame_n(input logic [7:0] d, input logic stop);
        exp_t e;
        e.data = stop ? last_n : d;
        e.perr = 1'b0;
        e.ferr = stop;
        e.due  = cyc + 10;
        q_n.push_back(e);
        if (!stop) last_n = d;
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(1'b0, d[i]);
        send_bit(1'b0, stop);
    endtask

    task automatic expect_drained(input string nm);
        n_checks++;
        if (q_p.size() != 0 || q_n.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_pulse pending par=%0d nopar=%0d, required 0 and 0",
                     nm, q_p.size(), q_n.size());
            q_p.delete();
            q_n.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        send_bit(1'b0, 1'b0);
        rst = 1'b0;
        last_p = 8'h00;
        last_n = 8'h00;
        n_checks++;
        if ({dout_p, valid_p, perr_p, ferr_p, busy_p} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_par got data=%h v=%b pe=%b fe=%b busy=%b, required all zero",
                     dout_p, valid_p, perr_p, ferr_p, busy_p);
        end
        n_checks++;
        if ({dout_n, valid_n, perr_n, ferr_n, busy_n} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_nopar got data=%h v=%b pe=%b fe=%b busy=%b, required all zero",
                     dout_n, valid_n, perr_n, ferr_n, busy_n);
        end
    endtask

    task automatic test_good_frame;
        int bh;
        send_frame_p(8'hA5, 1'b0, 1'b0, bh);
        expect_drained("good_frame");
        n_checks++;
        if (bh !== 10) begin
            n_fail++;
            $display("FAIL good_frame_busy got %0d busy cycles, required 10", bh);
        end
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (dout_p !== 8'hA5) begin
            n_fail++;
            $display("FAIL good_frame_hold got %h, required a5", dout_p);
        end
    endtask

    task automatic test_frame_err;
        int bh;
        send_frame_p(8'h3C, 1'b0, 1'b1, bh);
        expect_drained("frame_err");
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (busy_p !== 1'b0 || dout_p !== 8'hA5) begin
            n_fail++;
            $display("FAIL frame_err_after got busy=%b data=%h, required busy=0 data=a5", busy_p, dout_p);
        end
    endtask

    task automatic test_parity_err;
        int bh;
        send_frame_p(8'h01, 1'b0, 1'b0, bh);
        expect_drained("parity_err");
    endtask

    task automatic test_back_to_back;
        int bh;
        send_frame_p(8'hA5, 1'b0, 1'b0, bh);
        send_frame_p(8'h5A, 1'b0, 1'b0, bh);
        expect_drained("back_to_back");
        n_checks++;
        if (dout_p !== 8'h5A) begin
            n_fail++;
            $display("FAIL back_to_back_data got %h, required 5a", dout_p);
        end
    endtask

    task automatic test_reset_mid_frame;
        int bh;
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        send_bit(1'b1, 1'b0);
        rst = 1'b0;
        last_p = 8'h00;
        last_n = 8'h00;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (dout_p !== 8'h00 || busy_p !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame got data=%h busy=%b, required data=00 busy=0", dout_p, busy_p);
        end
        send_frame_p(8'h0F, 1'b0, 1'b0, bh);
        expect_drained("reset_mid_frame");
    endtask

    task automatic test_idle_no_parity;
        int busy_bad;
        busy_bad = 0;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0, 1'b0);
            if (busy_p !== 1'b0 || busy_n !== 1'b0) busy_bad++;
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL idle_busy got %0d busy cycles, required 0", busy_bad);
        end
        send_frame_n(8'h96, 1'b0);
        expect_drained("nopar_frame");
        n_checks++;
        if (dout_n !== 8'h96 || dout_p !== 8'h0F) begin
            n_fail++;
            $display("FAIL nopar_data got nopar=%h par=%h, required nopar=96 par=0f", dout_n, dout_p);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b0;
        din_p    = 1'b0;
        din_n    = 1'b0;
        last_p   = 8'h00;
        last_n   = 8'h00;
        test_reset();
        test_good_frame();
        test_frame_err();
        test_parity_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_no_parity();
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        expect_drained("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
